// File: rtl/fft_addr_seq.sv
// rtl/fft_addr_seq.sv - radix-2 DIT FFT address sequencer
// Issues read/twiddle addresses for every stage and a delayed write-back stream.
module fft_addr_seq #(
    parameter int LOG2N      = 11,
    parameter int BF_LATENCY = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             inverse_i,
    input  logic             hold_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_valid_o,
    output logic [LOG2N-1:0] rd_addr0_o,
    output logic [LOG2N-1:0] rd_addr1_o,
    output logic [LOG2N-1:0] tf_addr_o,
    output logic             wr_en_o,
    output logic [LOG2N-1:0] wr_addr0_o,
    output logic [LOG2N-1:0] wr_addr1_o
);

    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [LOG2N-2:0]   pair_q, pair_d;
    logic [3:0]         drain_q, drain_d;
    logic               inv_q, inv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rdv_q, rdv_d;
    logic [LOG2N-1:0]   a0_q, a0_d, a1_q, a1_d, tf_q, tf_d;

    logic [BF_LATENCY-1:0] wv_q;
    logic [LOG2N-1:0]      wa0_q [BF_LATENCY];
    logic [LOG2N-1:0]      wa1_q [BF_LATENCY];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
        return r;
    endfunction

    function automatic logic [LOG2N-1:0] rotr(input logic [LOG2N-1:0] x, input logic [SW-1:0] s);
        logic [2*LOG2N-1:0] dbl;
        dbl = {x, x} >> s;
        return dbl[LOG2N-1:0];
    endfunction

    logic [LOG2N-1:0] j_addr, k_addr, tw;
    int               sh_hi, sh_lo;

    always_comb begin
        j_addr = {pair_q, 1'b0};
        k_addr = {pair_q, 1'b1};
        sh_hi  = LOG2N - int'(stage_q);
        sh_lo  = LOG2N - 1 - int'(stage_q);
        // j >> (LOG2N-s) keeps at most s bits, so the left shift never overflows
        tw     = (j_addr >> sh_hi) << sh_lo;
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        pair_d  = pair_q;
        drain_d = drain_q;
        inv_d   = inv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdv_d   = 1'b0;
        a0_d    = a0_q;
        a1_d    = a1_q;
        tf_d    = tf_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = READ;
                    inv_d   = inverse_i;
                    stage_d = '0;
                    pair_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            READ: begin
                if (!hold_i) begin
                    rdv_d = 1'b1;
                    a0_d  = rotr(bitrev(j_addr), stage_q);
                    a1_d  = rotr(bitrev(k_addr), stage_q);
                    tf_d  = inv_q ? (LOG2N'(0) - tw) : tw;
                    if (&pair_q) begin
                        state_d = DRAIN;
                        pair_d  = '0;
                        drain_d = 4'(BF_LATENCY);
                    end else begin
                        pair_d = pair_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // leave on the edge that empties the counter so the next read lands right after the last write
                drain_d = drain_q - 4'd1;
                if (drain_d == 4'd0) begin
                    if (stage_q == SW'(LOG2N - 1)) begin
                        state_d = DONE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        pair_d  = '0;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            stage_q <= '0;
            pair_q  <= '0;
            drain_q <= '0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdv_q   <= 1'b0;
            a0_q    <= '0;
            a1_q    <= '0;
            tf_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            pair_q  <= pair_d;
            drain_q <= drain_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdv_q   <= rdv_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            tf_q    <= tf_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wv_q <= '0;
            for (int i = 0; i < BF_LATENCY; i++) begin
                wa0_q[i] <= '0;
                wa1_q[i] <= '0;
            end
        end else begin
            wv_q[0]  <= rdv_q;
            wa0_q[0] <= a0_q;
            wa1_q[0] <= a1_q;
            for (int i = 1; i < BF_LATENCY; i++) begin
                wv_q[i]  <= wv_q[i-1];
                wa0_q[i] <= wa0_q[i-1];
                wa1_q[i] <= wa1_q[i-1];
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_valid_o = rdv_q;
    assign rd_addr0_o = a0_q;
    assign rd_addr1_o = a1_q;
    assign tf_addr_o  = tf_q;
    assign wr_en_o    = wv_q[BF_LATENCY-1];
    assign wr_addr0_o = wa0_q[BF_LATENCY-1];
    assign wr_addr1_o = wa1_q[BF_LATENCY-1];

endmodule
